lcd_status_reader: RTL and testbench

- Read-side counterpart of lcd_driver for the HD44780-style 8-bit character LCD.
- Performs the instruction-register read cycle (RS=0, RW=1) and samples the busy flag (DB7) and address counter (DB6..0).
- Can run a single read, or poll until the busy flag clears, with a bounded retry count.
- Sits beside lcd_driver under digital_clock. The top muxes lcd_rs/lcd_rw/lcd_e onto the pins and tristates lcd_data while lcd_bus_req=1.

---
 rtl/lcd_status_reader.sv | 130 +++++++++++++
 tb/tb_lcd_status_reader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_status_reader.sv
// HD44780 instruction-register read (RS=0, RW=1): samples busy flag and address counter,
// either once or repeatedly until busy clears, bounded by MAX_POLLS reads.
module lcd_status_reader #(
   parameter int T_SETUP   = 1,
   parameter int E_HIGH    = 2,
   parameter int E_LOW     = 2,
   parameter int MAX_POLLS = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_clk,
   input  logic       rd_req,
   input  logic       poll_mode,
   input  logic [7:0] lcd_data_in,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic       lcd_bus_req,
   output logic       busy_flag,
   output logic [6:0] addr_cnt,
   output logic       rd_done,
   output logic       timeout
);

   localparam int TMAX   = (T_SETUP > E_HIGH) ? ((T_SETUP > E_LOW) ? T_SETUP : E_LOW)
                                              : ((E_HIGH > E_LOW) ? E_HIGH : E_LOW);
   localparam int TICK_W = $clog2(TMAX + 1);
   localparam int PW     = $clog2(MAX_POLLS + 1);

   localparam logic [TICK_W-1:0] SETUP_LAST = TICK_W'(T_SETUP - 1);
   localparam logic [TICK_W-1:0] E_HI_LAST  = TICK_W'(E_HIGH - 1);
   localparam logic [TICK_W-1:0] HOLD_LAST  = TICK_W'(E_LOW - 1);
   localparam logic [PW-1:0]     POLL_MAX   = PW'(MAX_POLLS);

   typedef enum logic [2:0] {IDLE, SETUP, E_HI, HOLD, CHECK, DONE} state_t;

   state_t            state, state_nxt;
   logic [TICK_W-1:0] tick_cnt;
   logic [TICK_W-1:0] tick_last;
   logic [PW-1:0]     poll_cnt;
   logic              poll_q;
   logic              phase_end;
   logic              poll_exhausted;
   logic              finish;
   logic              e_nxt, rw_nxt, done_nxt;

   function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] v);
      return (v == {PW{1'b1}}) ? v : v + 1'b1;
   endfunction

   assign lcd_rs = 1'b0;

   always_comb begin
      tick_last = '0;
      case (state)
         SETUP:   tick_last = SETUP_LAST;
         E_HI:    tick_last = E_HI_LAST;
         HOLD:    tick_last = HOLD_LAST;
         default: tick_last = '0;
      endcase
   end

   assign phase_end      = en_clk && (tick_cnt == tick_last);
   assign poll_exhausted = poll_q && busy_flag && (poll_cnt >= POLL_MAX);
   // The end-of-read decision is taken as HOLD expires so a finished read lands straight in DONE;
   // only a repeat poll spends the extra CHECK cycle.
   assign finish         = !poll_q || !busy_flag || (poll_cnt >= POLL_MAX);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (rd_req) state_nxt = SETUP;
         SETUP:   if (phase_end) state_nxt = E_HI;
         E_HI:    if (phase_end) state_nxt = HOLD;
         HOLD:    if (phase_end) state_nxt = finish ? DONE : CHECK;
         CHECK:   state_nxt = SETUP;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      e_nxt    = (state_nxt == E_HI);
      rw_nxt   = (state_nxt != IDLE);
      done_nxt = (state_nxt == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         tick_cnt    <= '0;
         poll_cnt    <= '0;
         poll_q      <= 1'b0;
         lcd_e       <= 1'b0;
         lcd_rw      <= 1'b0;
         lcd_bus_req <= 1'b0;
         rd_done     <= 1'b0;
         timeout     <= 1'b0;
         busy_flag   <= 1'b0;
         addr_cnt    <= '0;
      end else begin
         state       <= state_nxt;
         lcd_e       <= e_nxt;
         lcd_rw      <= rw_nxt;
         lcd_bus_req <= rw_nxt;
         rd_done     <= done_nxt;

         if (state_nxt != state || !(state inside {SETUP, E_HI, HOLD}))
            tick_cnt <= '0;
         else if (en_clk)
            tick_cnt <= tick_cnt + 1'b1;

         if (state == IDLE && rd_req) begin
            poll_q   <= poll_mode;
            poll_cnt <= '0;
            timeout  <= 1'b0;
         end

         if (state == E_HI && phase_end) begin
            busy_flag <= lcd_data_in[7];
            addr_cnt  <= lcd_data_in[6:0];
            poll_cnt  <= sat_inc(poll_cnt);
         end

         if (state == HOLD && phase_end && poll_exhausted)
            timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_lcd_status_reader.sv
// Scoreboard bench for lcd_status_reader: directed reads push expected results,
// a negedge monitor pops and compares on every rd_done.
module tb_lcd_status_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic       en_clk;
   logic       rd_req;
   logic       poll_mode;
   logic [7:0] lcd_data_in;
   logic       lcd_rs, lcd_rw, lcd_e, lcd_bus_req;
   logic       busy_flag;
   logic [6:0] addr_cnt;
   logic       rd_done, timeout;

   lcd_status_reader #(.T_SETUP(1), .E_HIGH(2), .E_LOW(2), .MAX_POLLS(4)) dut (
      .clk(clk), .rst(rst), .en_clk(en_clk), .rd_req(rd_req), .poll_mode(poll_mode),
      .lcd_data_in(lcd_data_in), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
      .lcd_bus_req(lcd_bus_req), .busy_flag(busy_flag), .addr_cnt(addr_cnt),
      .rd_done(rd_done), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       busy;
      logic [6:0] addr;
      logic       to;
      int         pulses;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;
   int   e_falls = 0;
   int   e_run = 0;
   int   last_e_width = 0;
   int   pulses_since = 0;
   logic e_prev = 1'b0;
   logic gate = 1'b0;
   int   gate_cnt = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic b, input logic [6:0] a, input logic t, input int p);
      exp_t e;
      e.busy = b; e.addr = a; e.to = t; e.pulses = p;
      exp_q.push_back(e);
   endtask

   task automatic wait_done(input int base, input int limit, input string name);
      int n;
      n = 0;
      while (done_cnt <= base && n < limit) begin
         tick();
         n++;
      end
      check({name, "_done_seen"}, int'(done_cnt > base), 1);
   endtask

   task automatic pulse_req(input logic pm);
      poll_mode = pm;
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
   endtask

   // Timing enable: every clk, or every 4th clk when gated.
   initial begin
      en_clk = 1'b1;
      forever begin
         @(negedge clk);
         gate_cnt++;
         en_clk = gate ? (gate_cnt % 4 == 0) : 1'b1;
      end
   end

   // Monitor / scoreboard.
   always @(negedge clk) begin
      if (lcd_e && !e_prev) pulses_since++;
      if (lcd_e) e_run++;
      else if (e_prev) begin
         last_e_width = e_run;
         e_run = 0;
         e_falls++;
      end
      e_prev = lcd_e;
      if (rd_done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_rd_done", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_busy_flag", int'(busy_flag), int'(e.busy));
            check("sb_addr_cnt", int'(addr_cnt), int'(e.addr));
            check("sb_timeout", int'(timeout), int'(e.to));
            check("sb_e_pulses", pulses_since, e.pulses);
         end
         pulses_since = 0;
      end
      if (!rst) pulses_since = 0;
   end

   initial begin
      int base, fbase, n;

      // Reset with a pending request and all-ones data.
      rst = 1'b0; rd_req = 1'b1; poll_mode = 1'b0; lcd_data_in = 8'hFF;
      repeat (3) tick();
      check("rst_lcd_rs", int'(lcd_rs), 0);
      check("rst_lcd_rw", int'(lcd_rw), 0);
      check("rst_lcd_e", int'(lcd_e), 0);
      check("rst_bus_req", int'(lcd_bus_req), 0);
      check("rst_busy_flag", int'(busy_flag), 0);
      check("rst_addr_cnt", int'(addr_cnt), 0);
      check("rst_rd_done", int'(rd_done), 0);
      check("rst_timeout", int'(timeout), 0);
      rst = 1'b1; rd_req = 1'b0;
      repeat (3) tick();
      check("idle_after_rst_rw", int'(lcd_rw), 0);
      check("idle_after_rst_e", int'(lcd_e), 0);

      // Single read with cycle-accurate timing.
      lcd_data_in = 8'h4A;
      push(1'b0, 7'h4A, 1'b0, 1);
      base = done_cnt;
      pulse_req(1'b0);                        // edge k
      check("single_k_rw", int'(lcd_rw), 1);
      check("single_k_bus_req", int'(lcd_bus_req), 1);
      check("single_k_e", int'(lcd_e), 0);
      tick();
      check("single_k1_e", int'(lcd_e), 1);
      tick();
      check("single_k2_e", int'(lcd_e), 1);
      tick();
      check("single_k3_e", int'(lcd_e), 0);
      check("single_k3_addr", int'(addr_cnt), 'h4A);
      tick();
      check("single_k4_done", int'(rd_done), 0);
      tick();
      check("single_k5_done", int'(rd_done), 1);
      tick();
      check("single_k6_done", int'(rd_done), 0);
      check("single_k6_rw", int'(lcd_rw), 0);
      check("single_k6_bus_req", int'(lcd_bus_req), 0);
      check("single_done_count", done_cnt - base, 1);

      // Poll: busy for three strobes, then clear.
      repeat (2) tick();
      lcd_data_in = 8'h80;
      push(1'b0, 7'h05, 1'b0, 4);
      base = done_cnt;
      fbase = e_falls;
      pulse_req(1'b1);
      n = 0;
      while (e_falls < fbase + 3 && n < 200) begin tick(); n++; end
      check("poll_three_strobes", int'(e_falls >= fbase + 3), 1);
      lcd_data_in = 8'h05;
      wait_done(base, 200, "poll");
      repeat (3) tick();
      check("poll_done_count", done_cnt - base, 1);

      // Timeout: busy never clears, MAX_POLLS=4.
      lcd_data_in = 8'hC0;
      push(1'b1, 7'h40, 1'b1, 4);
      base = done_cnt;
      pulse_req(1'b1);
      wait_done(base, 200, "timeout");
      repeat (3) tick();
      check("timeout_done_count", done_cnt - base, 1);
      check("timeout_held", int'(timeout), 1);

      // Gated en_clk and a request issued mid-transfer.
      gate = 1'b1;
      lcd_data_in = 8'h11;
      push(1'b0, 7'h11, 1'b0, 1);
      base = done_cnt;
      fbase = e_falls;
      pulse_req(1'b0);
      n = 0;
      while (!lcd_e && n < 100) begin tick(); n++; end
      check("gated_e_rose", int'(lcd_e), 1);
      pulse_req(1'b1);
      wait_done(base, 300, "gated");
      repeat (40) tick();
      check("gated_e_width", last_e_width, 8);
      check("gated_done_count", done_cnt - base, 1);
      check("gated_e_pulses", e_falls - fbase, 1);
      gate = 1'b0;
      repeat (4) tick();

      // Reset while E is high: no sample, bus released at once.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check("pre_abort_addr", int'(addr_cnt), 0);
      lcd_data_in = 8'h33;
      base = done_cnt;
      pulse_req(1'b0);
      n = 0;
      while (!lcd_e && n < 20) begin tick(); n++; end
      check("abort_e_rose", int'(lcd_e), 1);
      rst = 1'b0;
      tick();
      check("abort_e", int'(lcd_e), 0);
      check("abort_rw", int'(lcd_rw), 0);
      check("abort_bus_req", int'(lcd_bus_req), 0);
      check("abort_addr_cnt", int'(addr_cnt), 0);
      rst = 1'b1;
      repeat (12) tick();
      check("abort_no_done", done_cnt - base, 0);
      check("abort_idle_rw", int'(lcd_rw), 0);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
